// File: rtl/halt_dump_ctrl_pkg.sv
// Shared definitions for the run/halt/dump sequencer: FSM states, default
// parameter values and the index-width helper.
package halt_dump_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_DRAIN = 3'd1,
    ST_READ  = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [31:0] END_PC_DEF       = 32'd124;
  localparam logic [31:0] DUMP_BASE_DEF    = 32'd32;
  localparam int          DUMP_WORDS_DEF   = 96;
  localparam int          DRAIN_CYCLES_DEF = 2;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/halt_dump_ctrl_dmem_port_mux.sv
// Data-memory port select: pipeline M-stage pass-through while running,
// read-only dump addressing once the sequencer owns the port.
module dmem_port_mux (
  input  logic        dump_sel_i,
  input  logic [31:0] pipe_addr_i,
  input  logic        pipe_we_i,
  input  logic [31:0] pipe_wd_i,
  input  logic [31:0] dump_addr_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [31:0] mem_wd_o
);

  // Pipeline stores are dropped while dumping so the captured RAM stays frozen.
  always_comb begin
    mem_addr_o = pipe_addr_i;
    mem_we_o   = pipe_we_i;
    mem_wd_o   = pipe_wd_i;
    if (dump_sel_i) begin
      mem_addr_o = dump_addr_i;
      mem_we_o   = 1'b0;
      mem_wd_o   = 32'd0;
    end
  end

endmodule

// File: rtl/halt_dump_ctrl.sv
// Run/halt sequencer: halts the front end at END_PC, drains stores, then
// streams a RAM window out over valid/ready for result checking.
module halt_dump_ctrl
  import halt_dump_ctrl_pkg::*;
#(
  parameter logic [31:0] END_PC       = END_PC_DEF,
  parameter logic [31:0] DUMP_BASE    = DUMP_BASE_DEF,
  parameter int          DUMP_WORDS   = DUMP_WORDS_DEF,
  parameter int          DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  localparam int         IDX_W        = idx_w(DUMP_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic             memwritem,
  input  logic [31:0]      aluoutm,
  input  logic [31:0]      writedatam,
  output logic [31:0]      readdatam,
  output logic [31:0]      mem_addr,
  output logic             mem_we,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd,
  output logic             halt,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [IDX_W-1:0] dump_index,
  output logic [31:0]      dump_data,
  output logic             done
);

  localparam int               CNT_W      = idx_w(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DUMP_WORDS - 1);

  state_e             state_q, state_d;
  logic               halt_q, halt_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dump_sel;
  logic [31:0]        dump_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      halt_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      data_q  <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    valid_d = valid_q;
    done_d  = done_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (pc >= END_PC) begin
          state_d = ST_DRAIN;
          halt_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) state_d = ST_READ;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      ST_READ: begin
        data_d  = mem_rd;
        valid_d = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        // Word, index and valid hold until the consumer takes the word.
        if (dump_ready) begin
          valid_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: ;
      default: state_d = ST_RUN;
    endcase
  end

  assign dump_sel  = (state_q == ST_READ) || (state_q == ST_SEND) || (state_q == ST_DONE);
  assign dump_addr = (DUMP_BASE + 32'(idx_q)) << 2;

  dmem_port_mux u_mux (
    .dump_sel_i  (dump_sel),
    .pipe_addr_i (aluoutm),
    .pipe_we_i   (memwritem),
    .pipe_wd_i   (writedatam),
    .dump_addr_i (dump_addr),
    .mem_addr_o  (mem_addr),
    .mem_we_o    (mem_we),
    .mem_wd_o    (mem_wd)
  );

  assign readdatam  = mem_rd;
  assign halt       = halt_q;
  assign dump_valid = valid_q;
  assign dump_index = idx_q;
  assign dump_data  = data_q;
  assign done       = done_q;

endmodule

// File: tb/tb_halt_dump_ctrl.sv
// Bench for halt_dump_ctrl: pass-through vector table, random pass-through,
// and dump sequences checked against an event-level timeline model.
module tb_halt_dump_ctrl;

  localparam int N     = 96;
  localparam int BASE  = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'd0;
  logic        memwritem = 1'b0;
  logic [31:0] aluoutm = 32'd0;
  logic [31:0] writedatam = 32'd0;
  logic [31:0] readdatam;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        halt;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [6:0]  dump_index;
  logic [31:0] dump_data;
  logic        done;

  logic        preload = 1'b0;
  logic [31:0] ram [0:255];

  int n_cmp  = 0;
  int n_fail = 0;

  halt_dump_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .memwritem  (memwritem),
    .aluoutm    (aluoutm),
    .writedatam (writedatam),
    .readdatam  (readdatam),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd),
    .halt       (halt),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_index (dump_index),
    .dump_data  (dump_data),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Word-addressed RAM; preload puts k*3 in words BASE..BASE+N-1.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++)
        ram[i] <= (i >= BASE && i < BASE + N) ? 32'((i - BASE) * 3) : 32'd0;
    end else if (mem_we) begin
      ram[mem_addr[9:2]] <= mem_wd;
    end
  end
  assign mem_rd = ram[mem_addr[9:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input int k);
    return (k == 0) ? 32'hAA : 32'(k * 3);
  endfunction

  // Timeline model: first word valid 3 cycles after the trigger edge, each
  // later word one cycle after the edge that accepted the previous word,
  // done from the edge accepting the last word.
  task automatic run_dump(input int rmode, input int stop_idx, input bit do_store,
                          input int budget, output int end_cyc);
    int k     = 0;
    int cyc   = 0;
    int vfrom = 3;
    int stall = 0;
    bit exp_v, hs, r;
    while (1) begin
      exp_v = (k < N) && (cyc >= vfrom);
      chk("halt", {31'd0, halt}, 32'd1);
      chk("dump_valid", {31'd0, dump_valid}, {31'd0, exp_v});
      chk("done", {31'd0, done}, {31'd0, (k == N)});
      if (cyc >= 2 && k < N) begin
        chk("dump_mem_we", {31'd0, mem_we}, 32'd0);
        chk("dump_mem_addr", mem_addr, 32'((BASE + k) * 4));
      end
      if (exp_v) begin
        chk("dump_index", {25'd0, dump_index}, 32'(k));
        chk("dump_data", dump_data, exp_word(k));
      end
      if (k == N) break;
      if (exp_v && k == stop_idx) break;
      if (cyc >= budget) begin
        n_cmp++;
        n_fail++;
        $display("FAIL dump_timeout: got word %0d expected %0d words", k, N);
        break;
      end
      if (do_store && cyc == 0) begin
        memwritem = 1'b1; aluoutm = 32'd128; writedatam = 32'hAA;
        #1;
        chk("drain_store_we", {31'd0, mem_we}, 32'd1);
        chk("drain_store_addr", mem_addr, 32'd128);
        chk("drain_store_wd", mem_wd, 32'hAA);
      end else begin
        memwritem = 1'b0;
      end
      if (rmode == 0)                          r = 1'b1;
      else if (k == 7 && exp_v && stall < 5) begin r = 1'b0; stall++; end
      else                                     r = ($urandom_range(0, 3) != 0);
      dump_ready = r;
      hs = r && exp_v;
      tick();
      cyc++;
      if (hs) begin
        k++;
        vfrom = cyc + 1;
      end
    end
    dump_ready = 1'b0;
    memwritem  = 1'b0;
    end_cyc    = cyc;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    logic        exp_halt;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int endc;
    tbl[0] = '{32'd0,   1'b1, 32'd8,  32'd5,        1'b1, 32'd8,  32'd5,        1'b0};
    tbl[1] = '{32'd40,  1'b1, 32'd12, 32'd7,        1'b1, 32'd12, 32'd7,        1'b0};
    tbl[2] = '{32'd80,  1'b0, 32'd8,  32'd0,        1'b0, 32'd8,  32'd0,        1'b0};
    tbl[3] = '{32'd100, 1'b1, 32'd16, 32'hDEAD,     1'b1, 32'd16, 32'hDEAD,     1'b0};
    tbl[4] = '{32'd116, 1'b0, 32'd12, 32'h1234,     1'b0, 32'd12, 32'h1234,     1'b0};
    tbl[5] = '{32'd116, 1'b1, 32'd20, 32'hFFFFFFFF, 1'b1, 32'd20, 32'hFFFFFFFF, 1'b0};
    tbl[6] = '{32'd120, 1'b0, 32'd16, 32'd9,        1'b0, 32'd16, 32'd9,        1'b0};
    tbl[7] = '{32'd120, 1'b1, 32'd4,  32'd3,        1'b1, 32'd4,  32'd3,        1'b0};

    // Reset state and pass-through while held in reset
    preload = 1'b1; reset = 1'b1; pc = 32'd0;
    memwritem = 1'b1; aluoutm = 32'd8; writedatam = 32'd5;
    #1;
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, dump_valid}, 32'd0);
    chk("rst_index", {25'd0, dump_index}, 32'd0);
    chk("rst_data", dump_data, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd1);
    chk("rst_mem_addr", mem_addr, 32'd8);
    chk("rst_mem_wd", mem_wd, 32'd5);
    tick();
    preload = 1'b0; memwritem = 1'b0;
    tick();
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      pc = tbl[i].pc; memwritem = tbl[i].we; aluoutm = tbl[i].addr; writedatam = tbl[i].wd;
      #1;
      chk("tbl_mem_we", {31'd0, mem_we}, {31'd0, tbl[i].exp_we});
      chk("tbl_mem_addr", mem_addr, tbl[i].exp_addr);
      chk("tbl_mem_wd", mem_wd, tbl[i].exp_wd);
      chk("tbl_readdata", readdatam, ram[tbl[i].addr[9:2]]);
      tick();
      chk("tbl_halt", {31'd0, halt}, {31'd0, tbl[i].exp_halt});
    end
    chk("ram_word4", ram[4], 32'hDEAD);
    chk("ram_word5", ram[5], 32'hFFFFFFFF);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, d;
      logic        w;
      a = 32'($urandom_range(0, 31)) << 2;
      d = $urandom;
      w = 1'($urandom_range(0, 1));
      pc = 32'($urandom_range(0, 123)); memwritem = w; aluoutm = a; writedatam = d;
      #1;
      chk("rnd_mem_we", {31'd0, mem_we}, {31'd0, w});
      chk("rnd_mem_addr", mem_addr, a);
      chk("rnd_mem_wd", mem_wd, d);
      tick();
      chk("rnd_halt", {31'd0, halt}, 32'd0);
      if (w) chk("rnd_ram", ram[a[9:2]], d);
    end
    memwritem = 1'b0;

    // Trigger at pc=124, store in DRAIN, full-speed dump
    pc = 32'd124;
    #1;
    chk("pre_trigger_halt", {31'd0, halt}, 32'd0);
    tick();
    run_dump(0, -1, 1'b1, 400, endc);
    chk("done_cycle", 32'(endc), 32'd194);

    // DONE: pipeline store must be blocked
    memwritem = 1'b1; aluoutm = 32'd128; writedatam = 32'hFF;
    #1;
    chk("done_mem_we", {31'd0, mem_we}, 32'd0);
    chk("done_mem_wd", mem_wd, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_hold", {31'd0, done}, 32'd1);
      chk("done_halt", {31'd0, halt}, 32'd1);
      chk("done_valid", {31'd0, dump_valid}, 32'd0);
    end
    chk("done_ram32", ram[32], 32'hAA);
    memwritem = 1'b0;

    // Leave DONE via reset, then dump with backpressure and stop at word 40
    pc = 32'd0;
    reset = 1'b1;
    #1;
    chk("rst2_done", {31'd0, done}, 32'd0);
    chk("rst2_halt", {31'd0, halt}, 32'd0);
    reset = 1'b0;
    tick();
    pc = 32'd124;
    tick();
    run_dump(1, 40, 1'b0, 2000, endc);
    pc = 32'd0; aluoutm = 32'd36; memwritem = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_halt", {31'd0, halt}, 32'd0);
    chk("mid_rst_valid", {31'd0, dump_valid}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_index", {25'd0, dump_index}, 32'd0);
    chk("mid_rst_mem_addr", mem_addr, 32'd36);
    chk("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
    #1;
    reset = 1'b0;
    tick();
    chk("post_rst_halt", {31'd0, halt}, 32'd0);

    // Restart from index 0 with random backpressure and a word-7 stall
    pc = 32'd124;
    tick();
    run_dump(1, -1, 1'b0, 2000, endc);
    tick();
    chk("final_done", {31'd0, done}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/halt_dump_ctrl.md
Name: halt_dump_ctrl

Overview:
Run/halt sequencer for the 5-stage pipeline. It watches the fetch PC and, at a programmed end address, freezes the front end and drains in-flight stores. It then takes over the data-memory port and streams a window of RAM words out over a valid/ready interface for result checking. While running it is a transparent pass-through between pipeline M-stage and data memory.

Parameters:
END_PC, 32'd124, byte PC at or above which (unsigned compare) the halt sequence starts
DUMP_BASE, 32, first RAM word index to dump
DUMP_WORDS, 96, number of words dumped (>=1)
DRAIN_CYCLES, 2, cycles between halt assertion and memory takeover (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
pc  in  32  current fetch PC
memwritem  in  1  pipeline M-stage store enable
aluoutm  in  32  pipeline M-stage byte address
writedatam  in  32  pipeline M-stage store data
readdatam  out  32  load data returned to pipeline (= mem_rd, always)
mem_addr  out  32  data-memory byte address
mem_we  out  1  data-memory write enable
mem_wd  out  32  data-memory write data
mem_rd  in  32  data-memory read data (combinational read)
halt  out  1  to hazard unit: stall F and D, flush E
dump_valid  out  1  dump word available
dump_ready  in  1  consumer accepts word
dump_index  out  clog2(DUMP_WORDS)  word offset 0..DUMP_WORDS-1
dump_data  out  32  RAM[DUMP_BASE+dump_index]
done  out  1  dump complete

Behaviour:
- States: RUN, DRAIN, READ, SEND, DONE. Encoding lives in the package.
- Reset (async, any state, including mid-dump): state=RUN; halt=0, dump_valid=0, done=0, dump_index=0, dump_data=0, drain counter=0. Mux in pass-through.
- Port mux: in RUN and DRAIN, mem_addr=aluoutm, mem_we=memwritem, mem_wd=writedatam. In READ/SEND/DONE, mem_addr={DUMP_BASE+idx,2'b00}, mem_we=0, mem_wd=0. Pipeline stores are blocked there by design.
- RUN: at a clock edge with pc>=END_PC, go to DRAIN. halt is a registered output, high from that edge on. No trigger from any other state.
- DRAIN: counter loads 0 on entry and increments each cycle. When it reaches DRAIN_CYCLES-1, go to READ. Stores presented during DRAIN reach memory.
- READ: one cycle. dump_data<=mem_rd for the current idx, dump_valid<=1, go to SEND.
- SEND: dump_valid, dump_data and dump_index are held stable until dump_ready=1 at a clock edge (handshake).
  - On handshake with idx==DUMP_WORDS-1: dump_valid<=0, done<=1, go to DONE.
  - On any other handshake: idx<=idx+1, dump_valid<=0, go to READ.
- Throughput: 1 word per 2 cycles with dump_ready held high. dump_ready is ignored outside SEND.
- DONE: terminal until reset. halt=1, done=1, dump_valid=0.
- Timing from trigger edge T (DRAIN_CYCLES=2, ready high): first valid at T+3; word k valid at T+3+2k; done=1 from T+2+2*DUMP_WORDS (T+194 for 96 words).
- Address arithmetic is 32-bit unsigned; no wrap checking is performed.

Decomposition:
- Shared package: state enum, END_PC/DUMP_BASE/DUMP_WORDS/DRAIN_CYCLES defaults, index-width function.
- One natural sub-module: dmem_port_mux, the combinational pass-through/dump select.
- FSM, counters and output registers stay in halt_dump_ctrl.

Test Plan:
- Reset at cycle 0, pc=0 → halt=0, done=0, dump_valid=0. memwritem=1, aluoutm=8, writedatam=5 appears unchanged on mem_we/mem_addr/mem_wd.
- pc steps 116, 120, 124 → halt stays 0 through 120 and rises on the edge where pc=124 is sampled. A store to address 128 with value 0xAA presented in the next cycle (DRAIN) is written, and word 0 of the dump reads 0xAA.
- RAM[32+k]=k*3 preloaded, dump_ready=1 → 96 handshakes with dump_index 0..95, mem_addr 128..508, dump_data=k*3. done=1 at T+194 and stays 1.
- dump_ready=0 for 5 cycles while word 7 is valid → dump_valid, dump_index=7 and dump_data all stable. Index advances only after ready=1.
- reset pulsed while dump_index=40 → same cycle: halt=0, dump_valid=0, done=0, mux back to pass-through. A later pc>=124 restarts the dump from index 0.
- In DONE, drive memwritem=1, aluoutm=128, writedatam=0xFF → mem_we=0 and RAM[32] unchanged; done and halt remain 1.
